// File: rtl/sram_pkg.sv
// Shared types, constants and the byte-merge helper for the sram_mp_be storage macro.
package sram_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate around it.
  localparam int unsigned MERGE_MAX_DW = 512;
  localparam int unsigned MERGE_MAX_BE = MERGE_MAX_DW / 8;

  function automatic logic [MERGE_MAX_DW-1:0] merge_bytes(
    input logic [MERGE_MAX_DW-1:0] old_word,
    input logic [MERGE_MAX_DW-1:0] new_word,
    input logic [MERGE_MAX_BE-1:0] be
  );
    logic [MERGE_MAX_DW-1:0] res;
    res = old_word;
    for (int unsigned b = 0; b < MERGE_MAX_BE; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Sequential clear engine: walks the array CLR_PER_CYCLE rows per cycle and flags busy meanwhile.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter  int unsigned SIZE           = 1024,
  parameter  int unsigned CLR_PER_CYCLE  = 4,
  parameter  int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned AW             = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  output logic [AW-1:0] clr_ptr
);

  localparam logic [AW-1:0] LAST_PTR = AW'(SIZE - CLR_PER_CYCLE);
  localparam logic [AW-1:0] STEP     = AW'(CLR_PER_CYCLE);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          start_pend_q;

  // State register; a reset arms a clear for the first cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      start_pend_q <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      start_pend_q <= 1'b0;
    end
  end

  // Next state and row pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req || start_pend_q) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + STEP;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs decode straight from the state and pointer flops.
  always_comb begin
    busy    = (state_q == CLEAR);
    clr_ptr = ptr_q;
  end

endmodule

// File: rtl/sram_mp_be.sv
// Multi-port SRAM with per-byte write enables, port-priority merging, optional registered
// read with read-during-write policy, and a sequential clear engine.
module sram_mp_be
  import sram_pkg::*;
#(
  parameter  int unsigned SIZE           = 1024,
  parameter  int unsigned DATA_WIDTH     = 32,
  parameter  int unsigned RD_PORTS       = 2,
  parameter  int unsigned WR_PORTS       = 1,
  parameter  int unsigned RD_LATENCY     = 1,
  parameter  int unsigned RDW_MODE       = 1,
  parameter  int unsigned CLEAR_ON_RESET = 1,
  parameter  int unsigned CLR_PER_CYCLE  = 4,
  localparam int unsigned AW             = $clog2(SIZE),
  localparam int unsigned BE_W           = DATA_WIDTH / 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear_req,
  output logic                                 busy,
  input  logic [WR_PORTS-1:0]                  wr_en,
  input  logic [WR_PORTS-1:0][AW-1:0]          wr_addr,
  input  logic [WR_PORTS-1:0][BE_W-1:0]        wr_be,
  input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]  wr_data,
  input  logic [RD_PORTS-1:0]                  rd_en,
  input  logic [RD_PORTS-1:0][AW-1:0]          rd_addr,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic [RD_PORTS-1:0]                  rd_valid
);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [AW-1:0]         clr_ptr;
  logic [DATA_WIDTH-1:0] wr_word [WR_PORTS];

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BE_W-1:0]       be
  );
    return DATA_WIDTH'(merge_bytes(MERGE_MAX_DW'(old_word), MERGE_MAX_DW'(new_word),
                                   MERGE_MAX_BE'(be)));
  endfunction

  sram_clear_fsm #(
    .SIZE          (SIZE),
    .CLR_PER_CYCLE (CLR_PER_CYCLE),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clear_req(clear_req),
    .busy     (busy),
    .clr_ptr  (clr_ptr)
  );

  // Final word per write port: every port hitting the same row folds in, lowest port first,
  // so ports sharing a row all store the same merged value and the highest index wins per byte.
  always_comb begin
    for (int unsigned i = 0; i < WR_PORTS; i++) begin
      wr_word[i] = mem[wr_addr[i]];
      for (int unsigned k = 0; k < WR_PORTS; k++) begin
        if (wr_en[k] && (wr_addr[k] == wr_addr[i])) begin
          wr_word[i] = merge(wr_word[i], wr_data[k], wr_be[k]);
        end
      end
    end
  end

  // Array update: clear rows take precedence; writes are dropped while busy or in reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        for (int unsigned c = 0; c < CLR_PER_CYCLE; c++) begin
          mem[clr_ptr + AW'(c)] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < WR_PORTS; i++) begin
          if (wr_en[i]) mem[wr_addr[i]] <= wr_word[i];
        end
      end
    end
  end

  if (RD_LATENCY == 0) begin : g_comb_rd
    always_comb begin
      rd_data = '0;
      for (int unsigned j = 0; j < RD_PORTS; j++) begin
        if (!busy) rd_data[j] = mem[rd_addr[j]];
      end
      rd_valid = rd_en & {RD_PORTS{~busy}};
    end
  end else begin : g_reg_rd
    logic [DATA_WIDTH-1:0] rd_fwd [RD_PORTS];

    // Write-first reads see this cycle's merged write bytes; read-first sees the old row.
    always_comb begin
      for (int unsigned j = 0; j < RD_PORTS; j++) begin
        rd_fwd[j] = mem[rd_addr[j]];
        if (RDW_MODE == RDW_WRITE_FIRST) begin
          for (int unsigned k = 0; k < WR_PORTS; k++) begin
            if (wr_en[k] && (wr_addr[k] == rd_addr[j])) begin
              rd_fwd[j] = merge(rd_fwd[j], wr_data[k], wr_be[k]);
            end
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || busy) begin
        rd_data  <= '0;
        rd_valid <= '0;
      end else begin
        rd_valid <= rd_en;
        for (int unsigned j = 0; j < RD_PORTS; j++) begin
          if (rd_en[j]) rd_data[j] <= rd_fwd[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_mp_be.sv
// Bench for sram_mp_be: three instances (write-first, read-first, combinational) against one
// behavioural array model, plus directed literal checks.
module tb_sram_mp_be;

  localparam int unsigned SIZE = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned RDP  = 2;
  localparam int unsigned WRP  = 2;
  localparam int unsigned CPC  = 4;
  localparam int unsigned AW   = 4;
  localparam int unsigned BEW  = DW / 8;
  localparam int unsigned NCLR = SIZE / CPC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst, clear_req;
  logic [WRP-1:0]            wr_en;
  logic [WRP-1:0][AW-1:0]    wr_addr;
  logic [WRP-1:0][BEW-1:0]   wr_be;
  logic [WRP-1:0][DW-1:0]    wr_data;
  logic [RDP-1:0]            rd_en;
  logic [RDP-1:0][AW-1:0]    rd_addr;

  logic                      busy_wf, busy_rf, busy_c;
  logic [RDP-1:0][DW-1:0]    rd_data_wf, rd_data_rf, rd_data_c;
  logic [RDP-1:0]            rd_valid_wf, rd_valid_rf, rd_valid_c;

  sram_mp_be #(.SIZE(SIZE), .DATA_WIDTH(DW), .RD_PORTS(RDP), .WR_PORTS(WRP), .RD_LATENCY(1),
               .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLR_PER_CYCLE(CPC)) u_wf (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_wf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_wf), .rd_valid(rd_valid_wf));

  sram_mp_be #(.SIZE(SIZE), .DATA_WIDTH(DW), .RD_PORTS(RDP), .WR_PORTS(WRP), .RD_LATENCY(1),
               .RDW_MODE(0), .CLEAR_ON_RESET(1), .CLR_PER_CYCLE(CPC)) u_rf (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_rf),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_rf), .rd_valid(rd_valid_rf));

  sram_mp_be #(.SIZE(SIZE), .DATA_WIDTH(DW), .RD_PORTS(RDP), .WR_PORTS(WRP), .RD_LATENCY(0),
               .RDW_MODE(1), .CLEAR_ON_RESET(1), .CLR_PER_CYCLE(CPC)) u_c (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c), .rd_valid(rd_valid_c));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, remaining clear cycles, expected registered reads.
  logic [DW-1:0]          m_mem [SIZE];
  bit                     m_def [SIZE];
  int                     m_clr_left = 0;
  bit                     m_pend = 1'b0;
  bit                     m_live = 1'b0;
  logic [RDP-1:0][DW-1:0] m_rd_wf, m_rd_rf;
  logic [RDP-1:0]         m_val;

  always @(posedge clk) begin
    logic [DW-1:0] pre [SIZE];
    int base;
    if (rst) begin
      m_clr_left = 0;
      m_pend     = 1'b1;
      m_val      = '0;
      m_rd_wf    = '0;
      m_rd_rf    = '0;
      m_live     = 1'b1;
    end else if (m_clr_left > 0) begin
      base = (NCLR - m_clr_left) * CPC;
      for (int c = 0; c < CPC; c++) begin
        m_mem[base + c] = '0;
        m_def[base + c] = 1'b1;
      end
      m_clr_left--;
      m_val   = '0;
      m_rd_wf = '0;
      m_rd_rf = '0;
      m_pend  = 1'b0;
    end else begin
      pre = m_mem;
      for (int i = 0; i < WRP; i++) begin
        if (wr_en[i]) begin
          for (int b = 0; b < BEW; b++) begin
            if (wr_be[i][b]) m_mem[wr_addr[i]][b*8 +: 8] = wr_data[i][b*8 +: 8];
          end
        end
      end
      for (int j = 0; j < RDP; j++) begin
        if (rd_en[j]) begin
          m_rd_wf[j] = m_mem[rd_addr[j]];
          m_rd_rf[j] = pre[rd_addr[j]];
        end
      end
      m_val = rd_en;
      if (clear_req || m_pend) m_clr_left = NCLR;
      m_pend = 1'b0;
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      logic exp_busy;
      exp_busy = (m_clr_left > 0);
      check("busy_wf", DW'(busy_wf), DW'(exp_busy));
      check("busy_rf", DW'(busy_rf), DW'(exp_busy));
      check("busy_c", DW'(busy_c), DW'(exp_busy));
      for (int j = 0; j < RDP; j++) begin
        check($sformatf("rd_valid_wf[%0d]", j), DW'(rd_valid_wf[j]), DW'(m_val[j]));
        check($sformatf("rd_valid_rf[%0d]", j), DW'(rd_valid_rf[j]), DW'(m_val[j]));
        check($sformatf("rd_data_wf[%0d]", j), rd_data_wf[j], m_rd_wf[j]);
        check($sformatf("rd_data_rf[%0d]", j), rd_data_rf[j], m_rd_rf[j]);
        check($sformatf("rd_valid_c[%0d]", j), DW'(rd_valid_c[j]),
              DW'(rd_en[j] && !exp_busy));
        if (exp_busy) check($sformatf("rd_data_c[%0d]", j), rd_data_c[j], '0);
        else if (m_def[rd_addr[j]])
          check($sformatf("rd_data_c[%0d]", j), rd_data_c[j], m_mem[rd_addr[j]]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear_req = 1'b0;
    wr_en = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [BEW-1:0] be, input logic [DW-1:0] d);
    wr_en[p] = 1'b1; wr_addr[p] = AW'(a); wr_be[p] = be; wr_data[p] = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_en[p] = 1'b1; rd_addr[p] = AW'(a);
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy_wf && n < 50) begin
      n++;
      tick();
    end
    check(name, DW'(n), DW'(NCLR));
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < SIZE; a++) begin
      idle();
      rd(0, a);
      rd(1, SIZE - 1 - a);
      tick();
      check({name, "_wf0"}, rd_data_wf[0], '0);
      check({name, "_rf1"}, rd_data_rf[1], '0);
      check({name, "_valid"}, DW'(rd_valid_wf), DW'(2'b11));
    end
    idle();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle();
    repeat (3) tick();
    check("reset_busy", DW'(busy_wf), '0);
    check("reset_rd_valid", DW'(rd_valid_wf), '0);
    check("reset_rd_data", rd_data_wf[0], '0);

    // Clear after reset release lasts SIZE/CLR_PER_CYCLE cycles.
    rst = 1'b0;
    tick();
    count_busy("reset_clear_cycles");
    read_all_zero("post_reset_read");

    // Byte-enable partial write.
    wr(0, 5, 4'hF, 32'hDEADBEEF);
    tick();
    idle();
    wr(0, 5, 4'b0010, 32'h0000AA00);
    tick();
    idle();
    rd(0, 5);
    #1;
    check("be_merge_comb", rd_data_c[0], 32'hDEADAAEF);
    tick();
    check("be_merge_wf", rd_data_wf[0], 32'hDEADAAEF);
    check("be_merge_rf", rd_data_rf[0], 32'hDEADAAEF);

    // Same-row, same-cycle writes: higher port wins overlapping bytes.
    idle();
    wr(0, 3, 4'hF, 32'h11111111);
    wr(1, 3, 4'b0011, 32'h22222222);
    tick();
    idle();
    rd(1, 3);
    tick();
    check("port_priority", rd_data_wf[1], 32'h11112222);

    // Read-during-write on row 7 (still zero).
    idle();
    wr(0, 7, 4'hF, 32'h12345678);
    rd(0, 7);
    #1;
    check("rdw_comb_old", rd_data_c[0], 32'h0);
    tick();
    check("rdw_write_first", rd_data_wf[0], 32'h12345678);
    check("rdw_write_first_valid", DW'(rd_valid_wf[0]), 32'h1);
    check("rdw_read_first", rd_data_rf[0], 32'h0);
    idle();

    // Fill, clear_req with a coincident write, write during busy is dropped.
    for (int a = 0; a < SIZE; a++) begin
      idle();
      wr(0, a, 4'hF, $urandom | 32'h1);
      if (a == SIZE - 1) clear_req = 1'b1;
      tick();
    end
    idle();
    check("clear_started", DW'(busy_wf), 32'h1);
    wr(1, 2, 4'hF, 32'hFFFFFFFF);
    rd(0, 2);
    tick();
    check("busy_rd_valid", DW'(rd_valid_wf[0]), '0);
    check("busy_rd_data", rd_data_wf[0], '0);
    idle();
    n = 0;
    while (busy_wf && n < 50) begin
      n++;
      tick();
    end
    check("clear_done", DW'(busy_wf), '0);
    read_all_zero("post_clear_read");

    // Reset two cycles into a clear aborts it; a full clear follows release.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy_low", DW'(busy_wf), '0);
    rst = 1'b0;
    tick();
    count_busy("abort_reclear_cycles");

    // Randomized traffic on a narrow address range to force collisions.
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      clear_req = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < WRP; i++) begin
        wr_en[i]   = $urandom_range(0, 1);
        wr_addr[i] = AW'($urandom_range(0, 3));
        wr_be[i]   = BEW'($urandom);
        wr_data[i] = $urandom;
      end
      for (int j = 0; j < RDP; j++) begin
        rd_en[j]   = $urandom_range(0, 1);
        rd_addr[j] = AW'($urandom_range(0, 3));
      end
      tick();
    end
    rst = 1'b0;
    idle();
    n = 0;
    while ((busy_wf || n < 2) && n < 50) begin
      n++;
      tick();
    end
    check("final_idle", DW'(busy_wf), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
